// File: rtl/store_alignment_unit.sv
// store_alignment_unit: turns sb/sh/sw requests into one or two lane-aligned memory write beats
module store_alignment_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  st_valid,
  output logic                  st_ready,
  input  logic [ADDR_WIDTH-1:0] st_addr,
  input  logic [DATA_WIDTH-1:0] st_data,
  input  logic [2:0]            func3,
  output logic                  mem_req,
  input  logic                  mem_ack,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  output logic                  st_done,
  output logic                  st_err
);
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;
  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d, addr1_q, addr1_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d, wdata1_q, wdata1_d;
  logic [3:0]              be_q, be_d, be1_q, be1_d;
  logic                    done_q, done_d, err_q, err_d;
  logic                    is_sb, is_sw, legal;
  logic [7:0]              lane_mask;
  logic [DATA_WIDTH-1:0]   data_m;
  logic [2*DATA_WIDTH-1:0] shifted;
  logic [ADDR_WIDTH-1:0]   base;
  assign is_sb     = func3 == 3'b000;
  assign is_sw     = func3 == 3'b010;
  assign legal     = is_sb || is_sw || func3 == 3'b001;
  assign lane_mask = {4'b0000, is_sw ? 4'b1111 : is_sb ? 4'b0001 : 4'b0011} << st_addr[1:0];
  assign data_m    = st_data & {{16{is_sw}}, {8{!is_sb}}, 8'hFF};
  assign shifted   = {{DATA_WIDTH{1'b0}}, data_m} << {st_addr[1:0], 3'b000};
  assign base      = {st_addr[ADDR_WIDTH-1:2], 2'b00};
  assign st_ready  = state_q == IDLE;
  assign mem_req   = state_q != IDLE;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;
  assign st_done   = done_q;
  assign st_err    = err_q;
  // next state: capture both beats on accept, promote beat 1 on the beat-0 ack
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    addr1_d  = addr1_q;
    wdata1_d = wdata1_q;
    be1_d    = be1_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: if (st_valid) begin
        if (legal) begin
          state_d  = BEAT0;
          addr_d   = base;
          wdata_d  = shifted[DATA_WIDTH-1:0];
          be_d     = lane_mask[3:0];
          addr1_d  = base + ADDR_WIDTH'(4);
          wdata1_d = shifted[2*DATA_WIDTH-1:DATA_WIDTH];
          be1_d    = lane_mask[7:4];
        end else err_d = 1'b1;
      end
      BEAT0: if (mem_ack) begin
        if (be1_q != 4'b0000) begin
          state_d = BEAT1;
          addr_d  = addr1_q;
          wdata_d = wdata1_q;
          be_d    = be1_q;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      BEAT1: if (mem_ack) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and beat registers; reset abandons any store in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      addr1_q  <= '0;
      wdata1_q <= '0;
      be1_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      addr1_q  <= addr1_d;
      wdata1_q <= wdata1_d;
      be1_q    <= be1_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end
endmodule

// File: tb/tb_store_alignment_unit.sv
// tb_store_alignment_unit: randomized and directed stores checked against a byte-level memory model
module tb_store_alignment_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic [2:0]  func3 = '0;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        st_done;
  logic        st_err;
  int          total = 0;
  int          bad = 0;
  logic [31:0] e_addr [2];
  logic [31:0] e_wd [2];
  logic [3:0]  e_be [2];
  int          e_n;

  store_alignment_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .func3(func3),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .st_done(st_done), .st_err(st_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // each stored byte goes to address a+i; bytes sharing beat 0's word form beat 0, the rest beat 1
  task automatic model(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    int size;
    int b;
    int lane;
    logic [31:0] w0;
    logic [31:0] ab;
    size = (f == 3'd0) ? 1 : (f == 3'd1) ? 2 : 4;
    w0 = {a[31:2], 2'b00};
    for (int k = 0; k < 2; k++) begin
      e_be[k] = '0;
      e_wd[k] = '0;
    end
    for (int i = 0; i < size; i++) begin
      ab = a + i;
      b = ({ab[31:2], 2'b00} == w0) ? 0 : 1;
      lane = int'(ab[1:0]);
      e_be[b][lane] = 1'b1;
      e_wd[b][8*lane +: 8] = d[8*i +: 8];
    end
    e_addr[0] = w0;
    e_addr[1] = w0 + 32'd4;
    e_n = (e_be[1] != 4'b0000) ? 2 : 1;
  endtask

  // entered and left just after a falling edge; leaves in the st_done / st_err cycle
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f, input int stall);
    check("ready_before", st_ready, 1);
    st_valid = 1'b1;
    st_addr = a;
    st_data = d;
    func3 = f;
    @(negedge clk);
    st_valid = 1'b0;
    st_addr = $urandom;
    st_data = $urandom;
    func3 = 3'($urandom);
    if (f > 3'd2) begin
      check("err_pulse", st_err, 1);
      check("err_noreq", mem_req, 0);
      check("err_ready", st_ready, 1);
      check("err_nodone", st_done, 0);
      return;
    end
    model(a, d, f);
    for (int b = 0; b < e_n; b++) begin
      for (int k = 0; k <= stall; k++) begin
        check("req", mem_req, 1);
        check("busy", st_ready, 0);
        check("addr", mem_addr, e_addr[b]);
        check("be", mem_be, e_be[b]);
        check("wdata", mem_wdata, e_wd[b]);
        check("early_done", st_done, 0);
        mem_ack = (k == stall);
        @(negedge clk);
      end
      mem_ack = 1'b0;
    end
    check("done", st_done, 1);
    check("req_low", mem_req, 0);
    check("ready_done", st_ready, 1);
  endtask

  // idle cycles with stray acks that must be ignored
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      mem_ack = 1'($urandom);
      @(negedge clk);
      check("idle_done", st_done, 0);
      check("idle_err", st_err, 0);
      check("idle_req", mem_req, 0);
      check("idle_ready", st_ready, 1);
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    int r;
    repeat (2) @(negedge clk);
    check("rst_req", mem_req, 0);
    check("rst_be", mem_be, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_done", st_done, 0);
    check("rst_err", st_err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", st_ready, 1);
    store(32'h0000_0100, 32'hDEAD_BEEF, 3'b010, 1);
    idle(1);
    store(32'h0000_0203, 32'h1234_56AB, 3'b000, 0);
    idle(1);
    store(32'h0000_0307, 32'h0000_CAFE, 3'b001, 0);
    idle(1);
    store(32'hFFFF_FFFE, 32'h1122_3344, 3'b010, 3);
    idle(1);
    store(32'h0000_0040, 32'h5555_5555, 3'b011, 0);
    store(32'h0000_0400, 32'hA5A5_0F0F, 3'b010, 1);
    idle(2);
    st_valid = 1'b1;
    st_addr = 32'h0000_0501;
    st_data = 32'h0102_0304;
    func3 = 3'b010;
    @(negedge clk);
    st_valid = 1'b0;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("mid_b1_addr", mem_addr, 32'h0000_0504);
    check("mid_b1_be", mem_be, 4'b0001);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_req", mem_req, 0);
    check("mid_rst_be", mem_be, 0);
    check("mid_rst_done", st_done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rel_ready", st_ready, 1);
    check("mid_rel_done", st_done, 0);
    idle(2);
    repeat (80) begin
      r = $urandom_range(0, 9);
      store($urandom, $urandom, (r < 9) ? 3'(r % 3) : 3'($urandom_range(3, 7)), $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) idle(1);
    end
    idle(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/store_alignment_unit.md
Name: store_alignment_unit

Overview:
- Write-side counterpart of the load width-alignment path: takes a store request (sb/sh/sw) from the datapath and drives the data-memory write port.
- Produces word-aligned address, lane-shifted write data and byte enables.
- A store that crosses a word boundary is split into two sequential memory beats.
- Sits between the execute stage and the data memory, using a valid/ready handshake on the core side and a req/ack handshake on the memory side.

Parameters:
- ADDR_WIDTH, 32, byte-address width of st_addr and mem_addr.
- DATA_WIDTH, 32, data width. Fixed at 32 (4 byte lanes); other values are unsupported.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- st_valid  in  1  store request valid.
- st_ready  out  1  unit can accept a request; equals (state == IDLE).
- st_addr  in  ADDR_WIDTH  store byte address.
- st_data  in  DATA_WIDTH  store data, right-justified (rs2 value).
- func3  in  3  store width: 000 sb, 001 sh, 010 sw; all other codes illegal.
- mem_req  out  1  memory write beat valid (registered).
- mem_ack  in  1  memory accepted the current beat.
- mem_addr  out  ADDR_WIDTH  word-aligned beat address, [1:0] always 00.
- mem_wdata  out  DATA_WIDTH  lane-aligned write data.
- mem_be  out  4  byte enables; bit i enables mem_wdata[8i+7:8i].
- st_done  out  1  one-cycle pulse: store fully written.
- st_err  out  1  one-cycle pulse: illegal func3, no memory traffic.

Behaviour:
- Reset (rst_n low at an edge):
  - State goes to IDLE.
  - mem_req, mem_addr, mem_wdata, mem_be, st_done and st_err are 0.
  - Any in-flight store is abandoned: no further beats, no st_done.
  - st_ready is 1 in the first cycle after rst_n is sampled high.
- Accept: a request is taken on the edge where st_valid && st_ready. addr, data and func3 are captured; later changes on the st_* inputs are ignored.
- Size: sb = 1, sh = 2, sw = 4 bytes. Offset = st_addr[1:0].
- Lane mask (8 bits) = ((1 << size) - 1) << offset.
  - Beat-0 enables = mask[3:0].
  - Beat-1 enables = mask[7:4].
- Data: shifted = zero-extend-to-64(st_data masked to size) << (8 × offset).
  - Beat-0 wdata = shifted[31:0].
  - Beat-1 wdata = shifted[63:32].
  - Unused lanes are 0.
- Addresses:
  - Beat-0 address = {st_addr[ADDR_WIDTH-1:2], 2'b00}.
  - Beat-1 address = beat-0 address + 4, modulo 2^ADDR_WIDTH (wraps from top of memory to 0).
- States:
  - IDLE:
    - Legal accept → BEAT0.
    - Illegal accept → st_err = 1 next cycle; stay in IDLE; st_ready stays 1.
  - BEAT0:
    - mem_req = 1 with beat-0 addr/wdata/be, held stable until mem_ack is sampled high.
    - On ack: → BEAT1 if beat-1 enables ≠ 0, else → IDLE with st_done = 1 next cycle.
  - BEAT1:
    - mem_req = 1 with beat-1 values, held until ack.
    - On ack → IDLE with st_done = 1 next cycle.
- Timing:
  - Accept at edge N → mem_req high from cycle N+1.
  - Final ack at edge M → mem_req low and st_done high in cycle M+1.
  - Between beats, mem_req stays high; fields switch to beat-1 values at the beat-0 ack edge.
  - In the st_done cycle st_ready is already 1, so a new accept is legal (back-to-back stores: no idle bubble beyond the done cycle).
- Handshake rules:
  - mem_ack while mem_req = 0 is ignored.
  - mem_req is never asserted with mem_be = 0.
  - Single-beat stores never issue a beat 1.
- Split cases: sh at offset 3; sw at offset 1, 2 or 3. Every other legal case is single-beat.

Test Plan:
- Aligned sw:
  - Stimulus: addr 0x100, data 0xDEADBEEF, ack 1 cycle after req.
  - Required: one beat, mem_addr 0x100, be 1111, wdata 0xDEADBEEF; st_done pulse once; st_ready low exactly during the beat.
- sb offset 3:
  - Stimulus: addr 0x203, data 0x123456AB.
  - Required: one beat, mem_addr 0x200, be 1000, wdata 0xAB000000.
- Split sh:
  - Stimulus: addr 0x307, data 0x0000CAFE.
  - Required: beat 0 = 0x304 / be 1000 / wdata 0xFE000000; beat 1 = 0x308 / be 0001 / wdata 0x000000CA.
- Split sw with ack stall and wrap:
  - Stimulus: addr 0xFFFFFFFE, data 0x11223344, ack held low 3 cycles per beat.
  - Required: beat 0 = 0xFFFFFFFC / be 1100 / wdata 0x33440000, outputs stable through the stall; beat 1 = 0x00000000 / be 0011 / wdata 0x00001122; st_done after beat-1 ack.
- Illegal and back-to-back:
  - Stimulus: func3 011, then a new sw offered in the st_err cycle.
  - Required: st_err pulse, no mem_req for the illegal op, second store accepted immediately.
- Reset mid-store:
  - Stimulus: rst_n low during BEAT1 of a split sw.
  - Required: mem_req 0 the next cycle, no st_done, st_ready 1 after release.
